// File: rtl/cc_tx_arbiter_pkg.sv
// Shared constants and types for the command-layer TX arbiter.
// Includes the abort tag, arbiter state encodings and the abort-word helper.
package cc_tx_arbiter_pkg;

  localparam logic [15:0] CC_ABORT_TAG = 16'hDEAD;
  localparam logic [3:0]  CC_TKEEP_ALL = 4'b1111;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_XFER  = 2'd1,
    ARB_ABORT = 2'd2
  } arb_state_t;

  // Word that closes a frame whose owner stalled: {tag, 0x00, owner index}.
  function automatic logic [31:0] cc_abort_word(input logic [15:0] tag, input logic [7:0] idx);
    return {tag, 8'h00, idx};
  endfunction

endpackage

// File: rtl/cc_tx_arbiter_rr_pick.sv
// Combinational round-robin pick: first set request after ptr, wrapping modulo N.
// Shared with the RX dispatcher.
module cc_tx_arbiter_rr_pick #(
  parameter int  N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] idx,
  output logic         found
);

  logic [N-1:0] above;
  logic [N-1:0] req_hi;
  logic [N-1:0] pick_vec;
  logic [W-1:0] acc [N];

  // Requests strictly above the pointer win; otherwise wrap to the lowest one.
  for (genvar gi = 0; gi < N; gi++) begin : g_above
    assign above[gi] = (W'(gi) > ptr);
  end

  assign req_hi   = req & above;
  assign pick_vec = (|req_hi) ? req_hi : req;

  assign acc[0] = '0;
  for (genvar gi = 1; gi < N; gi++) begin : g_first
    assign acc[gi] = acc[gi-1] |
                     ((pick_vec[gi] & ~(|pick_vec[gi-1:0])) ? W'(gi) : '0);
  end

  assign idx   = acc[N-1];
  assign found = |req;

endmodule

// File: rtl/cc_tx_arbiter.sv
// Frame-granular round-robin arbiter sharing the 32-bit TX FIFO between command FSMs,
// with a one-entry output register and a watchdog that closes stalled frames.
module cc_tx_arbiter
  import cc_tx_arbiter_pkg::*;
#(
  parameter int          NUM_REQ        = 4,
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter logic [15:0] ABORT_TAG      = CC_ABORT_TAG,
  localparam int         GW             = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ*32-1:0] req_tdata,
  input  logic [NUM_REQ-1:0]    req_tvalid,
  input  logic [NUM_REQ-1:0]    req_tlast,
  output logic [NUM_REQ-1:0]    req_tready,
  output logic [31:0]           tx_data,
  output logic [0:3]            tx_tkeep,
  output logic                  tx_tvalid,
  output logic                  tx_tlast,
  input  logic                  tx_tready,
  output logic [GW-1:0]         grant_idx,
  output logic                  busy,
  output logic                  timeout_pulse
);

  localparam int            WW      = $clog2(TIMEOUT_CYCLES);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYCLES - 1);

  arb_state_t    state_reg, state_next;
  logic [GW-1:0] g_reg, g_next;
  logic [GW-1:0] rr_ptr_reg, rr_ptr_next;
  logic [WW-1:0] wd_reg, wd_next;
  logic [31:0]   tx_data_reg, tx_data_next;
  logic          tx_tvalid_reg, tx_tvalid_next;
  logic          tx_tlast_reg, tx_tlast_next;
  logic          pulse_reg, pulse_next;

  logic [31:0]   req_data_arr [NUM_REQ];
  logic [GW-1:0] pick_idx;
  logic          pick_found;
  logic          free, xfer, accept;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    assign req_data_arr[gi] = req_tdata[32*gi +: 32];
    assign req_tready[gi]   = xfer && free && (g_reg == GW'(gi));
  end

  cc_tx_arbiter_rr_pick #(.N(NUM_REQ)) u_rr_pick (
    .req   (req_tvalid),
    .ptr   (rr_ptr_reg),
    .idx   (pick_idx),
    .found (pick_found)
  );

  assign free   = !tx_tvalid_reg || tx_tready;
  assign xfer   = (state_reg == ARB_XFER);
  assign accept = xfer && req_tvalid[g_reg] && free;

  always_comb begin
    state_next     = state_reg;
    g_next         = g_reg;
    rr_ptr_next    = rr_ptr_reg;
    wd_next        = wd_reg;
    tx_data_next   = tx_data_reg;
    tx_tvalid_next = tx_tvalid_reg;
    tx_tlast_next  = tx_tlast_reg;
    pulse_next     = 1'b0;

    // Output register only changes on a load or a drain; state moves never touch it.
    if (accept) begin
      tx_data_next   = req_data_arr[g_reg];
      tx_tlast_next  = req_tlast[g_reg];
      tx_tvalid_next = 1'b1;
    end else if (state_reg == ARB_ABORT && free) begin
      tx_data_next   = cc_abort_word(ABORT_TAG, 8'(g_reg));
      tx_tlast_next  = 1'b1;
      tx_tvalid_next = 1'b1;
    end else if (tx_tready) begin
      tx_tvalid_next = 1'b0;
    end

    case (state_reg)
      ARB_IDLE: begin
        if (pick_found) begin
          g_next      = pick_idx;
          rr_ptr_next = pick_idx;
          wd_next     = '0;
          state_next  = ARB_XFER;
        end
      end
      ARB_XFER: begin
        if (accept) begin
          wd_next = '0;
          if (req_tlast[g_reg]) state_next = ARB_IDLE;
        end else if (!req_tvalid[g_reg]) begin
          // Only owner silence counts; FIFO backpressure never trips the watchdog.
          if (wd_reg == WD_LAST) state_next = ARB_ABORT;
          else                   wd_next = wd_reg + WW'(1);
        end
      end
      ARB_ABORT: begin
        if (free) begin
          pulse_next = 1'b1;
          state_next = ARB_IDLE;
        end
      end
      default: state_next = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ARB_IDLE;
      g_reg         <= '0;
      rr_ptr_reg    <= GW'(NUM_REQ - 1);
      wd_reg        <= '0;
      tx_data_reg   <= '0;
      tx_tvalid_reg <= 1'b0;
      tx_tlast_reg  <= 1'b0;
      pulse_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      g_reg         <= g_next;
      rr_ptr_reg    <= rr_ptr_next;
      wd_reg        <= wd_next;
      tx_data_reg   <= tx_data_next;
      tx_tvalid_reg <= tx_tvalid_next;
      tx_tlast_reg  <= tx_tlast_next;
      pulse_reg     <= pulse_next;
    end
  end

  assign tx_data       = tx_data_reg;
  assign tx_tvalid     = tx_tvalid_reg;
  assign tx_tlast      = tx_tlast_reg;
  assign tx_tkeep      = CC_TKEEP_ALL;
  assign grant_idx     = g_reg;
  assign busy          = (state_reg != ARB_IDLE);
  assign timeout_pulse = pulse_reg;

endmodule

// File: tb/tb_cc_tx_arbiter.sv
// Randomised and directed bench for cc_tx_arbiter against a cycle-level behavioural model.
// Requesters replay per-requester beat queues; TX beats are logged for literal checks.
module tb_cc_tx_arbiter;

  localparam int N  = 4;
  localparam int TO = 8;

  logic           clk        = 1'b0;
  logic           reset      = 1'b1;
  logic [N*32-1:0] req_tdata = '0;
  logic [N-1:0]   req_tvalid = '0;
  logic [N-1:0]   req_tlast  = '0;
  logic [N-1:0]   req_tready;
  logic [31:0]    tx_data;
  logic [0:3]     tx_tkeep;
  logic           tx_tvalid;
  logic           tx_tlast;
  logic           tx_tready  = 1'b1;
  logic [1:0]     grant_idx;
  logic           busy;
  logic           timeout_pulse;

  int checks = 0, failures = 0, cyc = 0, pulses = 0, tr_mode = 0;

  always #4 clk = ~clk;

  cc_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_tdata     (req_tdata),
    .req_tvalid    (req_tvalid),
    .req_tlast     (req_tlast),
    .req_tready    (req_tready),
    .tx_data       (tx_data),
    .tx_tkeep      (tx_tkeep),
    .tx_tvalid     (tx_tvalid),
    .tx_tlast      (tx_tlast),
    .tx_tready     (tx_tready),
    .grant_idx     (grant_idx),
    .busy          (busy),
    .timeout_pulse (timeout_pulse)
  );

  typedef struct { int r; logic [31:0] d; bit l; int gap; } beat_t;
  typedef struct { logic [31:0] d; bit l; int c; } obs_t;
  beat_t bq[$];
  obs_t  ob[$];
  int    wait_cnt[N];

  // Behavioural model: who owns the FIFO, whether an abort is pending, output register.
  bit          m_grant, m_abort, m_ov, m_ol, m_pulse;
  logic [31:0] m_od;
  int          m_owner, m_ptr, m_idle;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_grant = 0; m_abort = 0; m_ov = 0; m_ol = 0; m_pulse = 0;
    m_od = '0; m_owner = 0; m_ptr = N - 1; m_idle = 0;
  endtask

  function automatic int head(input int r);
    for (int i = 0; i < bq.size(); i++) if (bq[i].r == r) return i;
    return -1;
  endfunction

  task automatic push(input int r, input logic [31:0] d, input bit l, input int gap);
    beat_t b;
    b.r = r; b.d = d; b.l = l; b.gap = gap;
    bq.push_back(b);
  endtask

  task automatic step();
    bit free, acc;
    logic [N-1:0] rdy;
    int h, c;
    for (int r = 0; r < N; r++) begin
      h = head(r);
      if (h >= 0 && wait_cnt[r] >= bq[h].gap) begin
        req_tvalid[r] = 1'b1; req_tlast[r] = bq[h].l; req_tdata[32*r +: 32] = bq[h].d;
      end else begin
        req_tvalid[r] = 1'b0; req_tlast[r] = 1'b0; req_tdata[32*r +: 32] = '0;
      end
    end
    case (tr_mode)
      0:       tx_tready = 1'b1;
      1:       tx_tready = ($urandom_range(0, 9) < 7);
      2:       tx_tready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      default: tx_tready = 1'b0;
    endcase
    #1;
    free = !m_ov || tx_tready;
    rdy  = '0;
    if (m_grant && free) rdy[m_owner] = 1'b1;
    chk("tx_tvalid", 32'(tx_tvalid), 32'(m_ov));
    chk("tx_data", tx_data, m_od);
    chk("tx_tlast", 32'(tx_tlast), 32'(m_ol));
    chk("req_tready", 32'(req_tready), 32'(rdy));
    chk("grant_idx", 32'(grant_idx), 32'(m_owner));
    chk("busy", 32'(busy), 32'(m_grant || m_abort));
    chk("timeout_pulse", 32'(timeout_pulse), 32'(m_pulse));
    chk("tx_tkeep", 32'(tx_tkeep), 32'hF);
    if (tx_tvalid && tx_tready) ob.push_back('{tx_data, tx_tlast, cyc});
    if (timeout_pulse) pulses++;

    if (reset) begin
      model_reset();
    end else begin
      acc     = m_grant && free && req_tvalid[m_owner];
      m_pulse = m_abort && free;
      if (acc) begin
        m_od = req_tdata[32*m_owner +: 32]; m_ol = req_tlast[m_owner]; m_ov = 1;
      end else if (m_abort && free) begin
        m_od = {16'hDEAD, 8'h00, 8'(m_owner)}; m_ol = 1; m_ov = 1;
      end else if (tx_tready) begin
        m_ov = 0;
      end
      if (m_abort) begin
        if (free) m_abort = 0;
      end else if (m_grant) begin
        if (acc) begin
          m_idle = 0;
          if (req_tlast[m_owner]) m_grant = 0;
        end else if (!req_tvalid[m_owner]) begin
          m_idle++;
          if (m_idle == TO) begin m_grant = 0; m_abort = 1; end
        end
      end else begin
        for (int k = 1; k <= N; k++) begin
          c = (m_ptr + k) % N;
          if (req_tvalid[c]) begin
            m_owner = c; m_ptr = c; m_grant = 1; m_idle = 0;
            break;
          end
        end
      end
    end

    for (int r = 0; r < N; r++) begin
      h = head(r);
      if (h >= 0) begin
        if (req_tvalid[r] && rdy[r] && !reset) begin
          bq.delete(h); wait_cnt[r] = 0;
        end else if (!req_tvalid[r]) begin
          wait_cnt[r]++;
        end
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic run_idle(input string name, input int max_cycles);
    int n;
    n = 0;
    while ((bq.size() != 0 || m_grant || m_abort || m_ov) && n < max_cycles) begin
      step();
      n++;
    end
    if (n >= max_cycles) begin
      failures++;
      $display("FAIL %s drain did not complete within %0d cycles", name, max_cycles);
    end
  endtask

  task automatic clear_stim();
    bq.delete();
    for (int r = 0; r < N; r++) wait_cnt[r] = 0;
  endtask

  initial begin
    #10_000_000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] exp2 [8];
    logic [31:0] exp6 [6];
    int t0;
    exp2 = '{32'h01, 32'h02, 32'h21, 32'h22, 32'h31, 32'h32, 32'h03, 32'h04};
    exp6 = '{32'hC0, 32'hD0, 32'hC1, 32'hD1, 32'hC2, 32'hD2};
    clear_stim();
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_tx_tvalid", 32'(tx_tvalid), 32'h0);
    chk("rst_tx_data", tx_data, 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_grant_idx", 32'(grant_idx), 32'h0);
    chk("rst_req_tready", 32'(req_tready), 32'h0);
    reset = 1'b0;

    // Requester 1, three beats, full-rate FIFO
    ob.delete(); t0 = cyc;
    push(1, 32'h11, 0, 0); push(1, 32'h22, 0, 0); push(1, 32'h33, 1, 0);
    run_idle("t1", 60);
    chk("t1_count", 32'(ob.size()), 32'd3);
    if (ob.size() == 3) begin
      chk("t1_b0", ob[0].d, 32'h11); chk("t1_b1", ob[1].d, 32'h22); chk("t1_b2", ob[2].d, 32'h33);
      chk("t1_last", {29'd0, ob[0].l, ob[1].l, ob[2].l}, 32'b001);
      chk("t1_latency", 32'(ob[0].c - t0), 32'd2);
      chk("t1_back2back", 32'(ob[2].c - ob[0].c), 32'd2);
    end
    chk("t1_grant", 32'(grant_idx), 32'd1);

    // Requesters 0,2,3 ready at reset release; 0 re-requests immediately
    reset = 1'b1; step(); reset = 1'b0;
    ob.delete();
    push(0, 32'h01, 0, 0); push(0, 32'h02, 1, 0); push(0, 32'h03, 0, 0); push(0, 32'h04, 1, 0);
    push(2, 32'h21, 0, 0); push(2, 32'h22, 1, 0);
    push(3, 32'h31, 0, 0); push(3, 32'h32, 1, 0);
    run_idle("t2", 100);
    chk("t2_count", 32'(ob.size()), 32'd8);
    if (ob.size() == 8) for (int i = 0; i < 8; i++) chk("t2_order", ob[i].d, exp2[i]);

    // Backpressure pattern 1,0,0,1 during a 4-beat frame
    ob.delete(); pulses = 0; tr_mode = 2;
    push(0, 32'hA1, 0, 0); push(0, 32'hA2, 0, 0); push(0, 32'hA3, 0, 0); push(0, 32'hA4, 1, 0);
    run_idle("t3", 100);
    tr_mode = 0;
    chk("t3_count", 32'(ob.size()), 32'd4);
    if (ob.size() == 4) begin
      chk("t3_b0", ob[0].d, 32'hA1); chk("t3_b3", ob[3].d, 32'hA4);
      chk("t3_last", 32'(ob[3].l), 32'd1);
    end
    chk("t3_pulses", 32'(pulses), 32'd0);

    // Watchdog: requester 2 stalls after one beat
    ob.delete(); pulses = 0;
    push(2, 32'h77, 0, 0);
    run_idle("t4", 60);
    chk("t4_count", 32'(ob.size()), 32'd2);
    if (ob.size() == 2) begin
      chk("t4_beat", ob[0].d, 32'h77);
      chk("t4_abort_word", ob[1].d, 32'hDEAD0002);
      chk("t4_abort_last", 32'(ob[1].l), 32'd1);
      chk("t4_abort_delay", 32'(ob[1].c - ob[0].c), 32'd9);
    end
    chk("t4_pulses", 32'(pulses), 32'd1);
    chk("t4_busy", 32'(busy), 32'd0);

    // Reset while a beat is held by backpressure
    tr_mode = 3;
    push(1, 32'h55, 0, 0); push(1, 32'h56, 1, 0);
    for (int i = 0; i < 10 && !m_ov; i++) step();
    chk("t5_held", 32'(tx_tvalid), 32'd1);
    clear_stim();
    reset = 1'b1; step(); reset = 1'b0;
    chk("t5_rst_tvalid", 32'(tx_tvalid), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    tr_mode = 0; ob.delete();
    push(3, 32'h35, 1, 0); push(1, 32'h15, 1, 0); push(0, 32'h05, 1, 0);
    run_idle("t5", 60);
    chk("t5_count", 32'(ob.size()), 32'd3);
    if (ob.size() == 3) chk("t5_first", ob[0].d, 32'h05);

    // Back-to-back single-beat frames from 0 and 1
    ob.delete();
    for (int i = 0; i < 3; i++) begin
      push(0, 32'hC0 + 32'(i), 1, 0);
      push(1, 32'hD0 + 32'(i), 1, 0);
    end
    run_idle("t6", 60);
    chk("t6_count", 32'(ob.size()), 32'd6);
    if (ob.size() == 6) begin
      for (int i = 0; i < 6; i++) begin
        chk("t6_order", ob[i].d, exp6[i]);
        chk("t6_last", 32'(ob[i].l), 32'd1);
        if (i > 0) chk("t6_spacing", 32'(ob[i].c - ob[i-1].c), 32'd2);
      end
    end

    // Random traffic with random backpressure and occasional stalls
    tr_mode = 1;
    for (int n = 0; n < 3000; n++) begin
      for (int r = 0; r < N; r++) begin
        if (head(r) < 0 && $urandom_range(0, 9) == 0) begin
          int nb;
          nb = $urandom_range(1, 5);
          for (int b = 0; b < nb; b++)
            push(r, $urandom, (b == nb - 1),
                 ($urandom_range(0, 7) == 0) ? $urandom_range(0, 12) : 0);
        end
      end
      step();
    end
    run_idle("random_drain", 1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
